// File: rtl/shift_pkg.sv
// shift_pkg: opcode and FSM state types shared by the iterative shifter, plus opcode validity check
package shift_pkg;
  typedef enum logic [3:0] {
    OP_SLL = 4'b0010,
    OP_SRL = 4'b0011,
    OP_SRA = 4'b0100,
    OP_ROL = 4'b0101,
    OP_ROR = 4'b0110
  } op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_valid_op(input logic [3:0] op);
    return op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational k-bit shift/rotate of data by op (data, k, op in; y out)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP = 1
) (
  input  logic [WIDTH-1:0]     data,
  input  logic [$clog2(STEP):0] k,
  input  logic [3:0]           op,
  output logic [WIDTH-1:0]     y
);
  assign y = op == OP_SLL ? data << k :
             op == OP_SRL ? data >> k :
             op == OP_SRA ? WIDTH'($signed(data) >>> k) :
             op == OP_ROL ? (data << k) | (data >> (WIDTH - int'(k))) :
             op == OP_ROR ? (data >> k) | (data << (WIDTH - int'(k))) : data;
endmodule

// File: rtl/shift_iter.sv
// shift_iter: multi-cycle shift/rotate unit; in_valid/in_ready/a/shamt/op request, out_valid/out_ready/result/zero response
module shift_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int KW = $clog2(STEP) + 1;
  state_t state, state_n;
  logic [WIDTH-1:0] data, data_n, stepped;
  logic [SHW-1:0] rem, rem_n;
  logic [3:0] op_q, op_n;
  logic [KW-1:0] k;
  assign k = int'(rem) < STEP ? KW'(rem) : KW'(STEP);
  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .data(data),
    .k(k),
    .op(op_q),
    .y(stepped)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      data <= '0;
      rem <= '0;
      op_q <= '0;
    end else begin
      state <= state_n;
      data <= data_n;
      rem <= rem_n;
      op_q <= op_n;
    end
  always_comb begin
    state_n = state;
    data_n = data;
    rem_n = rem;
    op_n = op_q;
    if (state == IDLE && in_valid) begin
      data_n = is_valid_op(op) ? a : '0;
      rem_n = shamt;
      op_n = op;
      state_n = shamt == '0 || !is_valid_op(op) ? DONE : BUSY;
    end else if (state == BUSY) begin
      data_n = stepped;
      rem_n = rem - SHW'(k);
      state_n = rem == SHW'(k) ? DONE : BUSY;
    end else if (state == DONE && out_ready)
      state_n = IDLE;
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign result = data;
  assign zero = data == '0;
endmodule

// File: tb/tb_shift_iter.sv
// tb_shift_iter: directed and randomized checks of shift_iter at STEP=1 and STEP=4 against a bitwise reference model
module tb_shift_iter;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid [2];
  logic in_ready [2];
  logic out_valid [2];
  logic out_ready [2];
  logic zero [2];
  logic [W-1:0] a [2];
  logic [W-1:0] result [2];
  logic [4:0] shamt [2];
  logic [3:0] op [2];
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  shift_iter #(.WIDTH(W), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]),
    .shamt(shamt[0]), .op(op[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .zero(zero[0])
  );
  shift_iter #(.WIDTH(W), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]),
    .shamt(shamt[1]), .op(op[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .zero(zero[1])
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input int n, input logic [3:0] o);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      case (o)
        4'b0010: r[i] = i >= n ? x[(i - n) % W] : 1'b0;
        4'b0011: r[i] = i + n < W ? x[(i + n) % W] : 1'b0;
        4'b0100: r[i] = i + n < W ? x[(i + n) % W] : x[W-1];
        4'b0101: r[i] = x[(i - n + W) % W];
        4'b0110: r[i] = x[(i + n) % W];
        default: r[i] = 1'b0;
      endcase
    return r;
  endfunction
  function automatic int latency(input int d, input int n, input logic [3:0] o);
    int st;
    st = d ? 4 : 1;
    return (o inside {[4'd2:4'd6]}) && n != 0 ? 1 + (n + st - 1) / st : 1;
  endfunction
  task automatic wait_valid(input int d, output int cyc);
    cyc = 1;
    while (out_valid[d] !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic xact(input int d, input logic [W-1:0] av, input logic [4:0] n,
                      input logic [3:0] o, input logic [W-1:0] want, input string tag);
    int cyc;
    chk({tag, " in_ready idle"}, W'(in_ready[d]), 1);
    in_valid[d] = 1'b1;
    a[d] = av;
    shamt[d] = n;
    op[d] = o;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    a[d] = $urandom;
    shamt[d] = 5'($urandom);
    op[d] = 4'($urandom);
    chk({tag, " in_ready after accept"}, W'(in_ready[d]), 0);
    wait_valid(d, cyc);
    chk({tag, " latency"}, W'(cyc), W'(latency(d, int'(n), o)));
    chk({tag, " result"}, result[d], want);
    chk({tag, " zero"}, W'(zero[d]), W'(want == '0));
    @(posedge clk);
    #1;
    chk({tag, " in_ready after handshake"}, W'(in_ready[d]), 1);
    chk({tag, " out_valid after handshake"}, W'(out_valid[d]), 0);
  endtask
  initial begin
    int cyc;
    logic [W-1:0] exp1, av;
    logic [4:0] n;
    logic [3:0] o;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
      a[d] = '0;
      shamt[d] = '0;
      op[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset in_ready", W'(in_ready[d]), 1);
      chk("reset out_valid", W'(out_valid[d]), 0);
      chk("reset result", result[d], 0);
      chk("reset zero", W'(zero[d]), 1);
    end
    xact(0, 32'h0000_0001, 5'd31, 4'b0010, 32'h8000_0000, "sll31 s1");
    xact(1, 32'h8000_00F0, 5'd5, 4'b0100, 32'hFC00_0007, "sra5 s4");
    xact(1, 32'h0000_00A5, 5'd4, 4'b0110, 32'h5000_000A, "ror4 s4");
    xact(0, 32'h0000_00A5, 5'd4, 4'b0110, 32'h5000_000A, "ror4 s1");
    xact(1, 32'h1234_5678, 5'd0, 4'b0101, 32'h1234_5678, "rol0 s4");
    xact(0, 32'hFFFF_FFFF, 5'd7, 4'b0000, 32'h0000_0000, "badop s1");
    xact(1, 32'hFFFF_FFFF, 5'd9, 4'b1111, 32'h0000_0000, "badop s4");
    xact(0, 32'h0000_0001, 5'd1, 4'b0011, 32'h0000_0000, "srl1 s1");
    xact(1, 32'h8000_0001, 5'd3, 4'b0101, 32'h0000_000C, "rol3 s4");
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1;
    a[1] = 32'h0F0F_0000;
    shamt[1] = 5'd8;
    op[1] = 4'b0011;
    exp1 = 32'h000F_0F00;
    @(posedge clk);
    #1;
    a[1] = 32'h0000_0003;
    shamt[1] = 5'd1;
    op[1] = 4'b0010;
    wait_valid(1, cyc);
    chk("bp latency", W'(cyc), 3);
    repeat (10) begin
      chk("bp out_valid", W'(out_valid[1]), 1);
      chk("bp result", result[1], exp1);
      chk("bp in_ready", W'(in_ready[1]), 0);
      @(posedge clk);
      #1;
    end
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp in_ready after handshake", W'(in_ready[1]), 1);
    chk("bp out_valid after handshake", W'(out_valid[1]), 0);
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    chk("bp second accepted", W'(in_ready[1]), 0);
    wait_valid(1, cyc);
    chk("bp second latency", W'(cyc), 2);
    chk("bp second result", result[1], 32'h0000_0006);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    a[0] = 32'h0000_0001;
    shamt[0] = 5'd20;
    op[0] = 4'b0010;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst in_ready", W'(in_ready[0]), 1);
    chk("rst out_valid", W'(out_valid[0]), 0);
    chk("rst result", result[0], 0);
    chk("rst zero", W'(zero[0]), 1);
    cyc = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid[0] === 1'b1) cyc++;
    end
    chk("rst no stale result", W'(cyc), 0);
    xact(0, 32'h0000_0001, 5'd20, 4'b0010, 32'h0010_0000, "post rst sll20");
    for (int i = 0; i < 80; i++) begin
      av = $urandom;
      n = 5'($urandom);
      o = $urandom_range(0, 7) == 0 ? 4'($urandom_range(7, 15)) : 4'($urandom_range(2, 6));
      xact(i % 2, av, n, o, model(av, int'(n), o), i % 2 ? "rnd s4" : "rnd s1");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/shift_iter.md
# shift_iter

Multi-cycle, parametrised shift/rotate unit for the RISC-V ALU datapath, the sequential successor to the single-cycle combinational shifter. It accepts one operation per valid/ready handshake and shifts an internal register by up to STEP bits per clock. It returns the result and a zero flag through an output valid/ready handshake. Rotate-left and rotate-right modes are added, and the shift amount follows RISC-V masking semantics.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 8.
- STEP, 1: maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- SHW, $clog2(WIDTH): derived; shift-amount width, not overridable.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- a  in  WIDTH  operand to shift.
- shamt  in  SHW  shift amount; only low SHW bits exist, so it is implicitly masked mod WIDTH.
- op  in  4  0010 SLL, 0011 SRL, 0100 SRA, 0101 ROL, 0110 ROR; any other value is invalid.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  shifted value (registered).
- zero  out  1  result == 0.

## Operation
- States are IDLE, BUSY, and DONE.
- **IDLE:** in_ready=1.
  - On in_valid, capture a into the data register, shamt into the remaining counter, and op.
  - If shamt==0 or op is invalid, go to DONE. An invalid op loads the data register with 0.
  - Otherwise go to BUSY.
- **BUSY:** in_ready=0, out_valid=0.
  - Each cycle, k = min(STEP, remaining).
  - Apply a k-bit step: SLL shifts left zero-fill; SRL shifts right zero-fill; SRA shifts right sign-fill from the current MSB; ROL/ROR rotate.
  - Decrement remaining by k. When remaining reaches 0 after the step, go to DONE.
- **DONE:** out_valid=1, in_ready=0.
  - result and zero are held stable until out_ready=1.
  - On handshake, go to IDLE.
- zero = (data register == 0), driven combinationally from the register. It is meaningful only while out_valid=1.
- Inputs are sampled only at the in_valid && in_ready edge. Later changes to a, shamt, or op have no effect.
- out_valid must not drop without out_ready. result must not change while out_valid=1.
- rst at any time, including mid-BUSY or in DONE with a pending result, returns to IDLE. Any in-flight operation is discarded and no result is emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, zero=1; internal counter=0, stored op=0.
- Let the accept edge be cycle t.
  - out_valid rises at t+1+ceil(shamt/STEP).
  - With shamt==0 or an invalid op, out_valid rises at t+1.
- Worst case at WIDTH=32, STEP=1 (shamt=31) is t+32.
- A DONE-to-IDLE handshake on cycle u gives in_ready=1 at u+1. The minimum initiation interval is latency+1 with out_ready held high.
- There are no combinational paths from in_valid to in_ready or from out_ready to out_valid.

## Structure
- **Package shift_pkg:**
  - op_t, a 4-bit enum holding the opcode constants above; the single-cycle shifter's codes are kept identical.
  - state_t enum {IDLE, BUSY, DONE}.
  - Function is_valid_op.
- **Sub-module shift_step:**
  - Purely combinational; parameters WIDTH and STEP.
  - Inputs are data, amount k (width $clog2(STEP)+1), and op; output is the stepped data.
  - It is instantiated once.
- The top module holds the FSM, data register, counter, and handshakes.
- The target is roughly 150–250 lines total.

## Test plan
- **SLL, STEP=1:** WIDTH=32, a=0x0000_0001, shamt=31, op=0010, out_ready=1.
  - Expect result=0x8000_0000 and zero=0.
  - out_valid rises exactly 32 cycles after accept.
- **SRA sign fill, STEP=4:** a=0x8000_00F0, shamt=5, op=0100.
  - Expect result=0xFC00_0007.
  - Latency is 1+2=3 cycles: steps of 4 then 1.
- **Rotate and zero-shift:**
  - ROR: a=0x0000_00A5, shamt=4, op=0110 gives 0x5000_000A.
  - ROL: a=0x1234_5678, shamt=0 gives 0x1234_5678, with out_valid at t+1 and no BUSY cycles.
- **Invalid op and zero flag:**
  - op=0000 with a=0xFFFF_FFFF gives result=0 and zero=1 at t+1.
  - SRL with a=0x0000_0001, shamt=1 gives result=0 and zero=1.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid.
  - result and out_valid stay stable and in_ready stays 0.
  - A second in_valid during that window is not accepted and is taken only after the handshake.
- **Reset mid-operation:** assert rst during BUSY of a shamt=20 SLL.
  - Next cycle: in_ready=1, out_valid=0, result=0.
  - No stale result appears; a fresh request then completes correctly.
